// File: rtl/spi_flash_arb_pkg.sv
// Shared types and defaults for the SPI boot-flash arbiter: arbiter state encoding,
// owner identifiers and default timing parameters.
package spi_flash_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT0  = 2'd1,
    GRANT1  = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  localparam logic REQ_DSP = 1'b0;
  localparam logic REQ_CPU = 1'b1;

  localparam int RELEASE_CYCLES_DEF = 4;
  localparam int TIMEOUT_CYCLES_DEF = 1 << 20;
  localparam int SYNC_STAGES_DEF    = 2;

endpackage

// File: rtl/spi_flash_arbiter_cs_sync.sv
// Multi-flop synchroniser for an active-low SPI chip-select; resets to the
// deasserted level (1) so that no request is seen out of reset.
module spi_cs_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic sysclk,
  input  logic reset,
  input  logic cs_inv_async,
  output logic cs_inv_sync
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], cs_inv_async};
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign cs_inv_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_flash_arbiter.sv
// Two-master arbiter for the shared SPI boot/config flash (DSP = requester 0,
// CPU = requester 1). Optional grant watchdog: define SPI_FLASH_ARB_TIMEOUT_EN.
module spi_flash_arbiter
  import spi_flash_arb_pkg::*;
#(
  parameter int RELEASE_CYCLES = RELEASE_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int SYNC_STAGES    = SYNC_STAGES_DEF
) (
  input  logic sysclk,
  input  logic reset,
  input  logic enable,
  input  logic req0_cs_INV,
  input  logic req0_clk,
  input  logic req0_mosi,
  output logic req0_miso,
  output logic req0_gnt,
  input  logic req1_cs_INV,
  input  logic req1_clk,
  input  logic req1_mosi,
  output logic req1_miso,
  output logic req1_gnt,
  output logic flash_cs_INV,
  output logic flash_clk,
  output logic flash_mosi,
  input  logic flash_miso,
  input  logic contention_clr,
  output logic contention,
  output logic timeout_fault
);

  if (SYNC_STAGES < 2 || RELEASE_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("spi_flash_arbiter: illegal parameter value");
  end

  localparam int REL_W = (RELEASE_CYCLES < 2) ? 1 : $clog2(RELEASE_CYCLES + 1);
  localparam logic [REL_W-1:0] REL_LAST = REL_W'(RELEASE_CYCLES - 1);

  arb_state_e state_q, state_d;
  logic [REL_W-1:0] rel_cnt_q, rel_cnt_d;
  logic last_owner_q, last_owner_d;
  logic contention_q, contention_d;
  logic cs0_prev_q, cs1_prev_q;
  logic cs0_sync, cs1_sync;
  logic fall0, fall1;
  logic req0, req1;
  logic tmo_hit;

  spi_cs_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync0 (
    .sysclk       (sysclk),
    .reset        (reset),
    .cs_inv_async (req0_cs_INV),
    .cs_inv_sync  (cs0_sync)
  );

  spi_cs_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync1 (
    .sysclk       (sysclk),
    .reset        (reset),
    .cs_inv_async (req1_cs_INV),
    .cs_inv_sync  (cs1_sync)
  );

  // Contention is a fresh CS assertion by the non-owner; a requester already
  // waiting when the other won a tie does not count.
  assign fall0 = cs0_prev_q & ~cs0_sync;
  assign fall1 = cs1_prev_q & ~cs1_sync;

`ifdef SPI_FLASH_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic timeout_fault_q, timeout_fault_d;
  logic lock0_q, lock0_d, lock1_q, lock1_d;

  assign tmo_hit = (state_q == GRANT0 || state_q == GRANT1) && (tmo_cnt_q == TMO_LAST);
  assign req0    = ~cs0_sync & ~lock0_q;
  assign req1    = ~cs1_sync & ~lock1_q;

  always_comb begin
    tmo_cnt_d       = '0;
    timeout_fault_d = timeout_fault_q | tmo_hit;
    lock0_d         = lock0_q;
    lock1_d         = lock1_q;
    if ((state_q == GRANT0 || state_q == GRANT1) && tmo_cnt_q != TMO_LAST) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end else if (state_q == GRANT0 || state_q == GRANT1) begin
      tmo_cnt_d = tmo_cnt_q;
    end
    // A timed-out owner must show a deasserted CS before it may request again.
    if (tmo_hit && state_q == GRANT0) begin
      lock0_d = 1'b1;
    end else if (cs0_sync) begin
      lock0_d = 1'b0;
    end
    if (tmo_hit && state_q == GRANT1) begin
      lock1_d = 1'b1;
    end else if (cs1_sync) begin
      lock1_d = 1'b0;
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      tmo_cnt_q       <= '0;
      timeout_fault_q <= 1'b0;
      lock0_q         <= 1'b0;
      lock1_q         <= 1'b0;
    end else begin
      tmo_cnt_q       <= tmo_cnt_d;
      timeout_fault_q <= timeout_fault_d;
      lock0_q         <= lock0_d;
      lock1_q         <= lock1_d;
    end
  end

  assign timeout_fault = timeout_fault_q;
`else
  assign tmo_hit       = 1'b0;
  assign req0          = ~cs0_sync;
  assign req1          = ~cs1_sync;
  assign timeout_fault = 1'b0;
`endif

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q      <= IDLE;
      rel_cnt_q    <= '0;
      last_owner_q <= REQ_CPU;
      contention_q <= 1'b0;
      cs0_prev_q   <= 1'b1;
      cs1_prev_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      rel_cnt_q    <= rel_cnt_d;
      last_owner_q <= last_owner_d;
      contention_q <= contention_d;
      cs0_prev_q   <= cs0_sync;
      cs1_prev_q   <= cs1_sync;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          if (req0 && req1) begin
            state_d = (last_owner_q == REQ_DSP) ? GRANT1 : GRANT0;
          end else if (req0) begin
            state_d = GRANT0;
          end else if (req1) begin
            state_d = GRANT1;
          end
        end
      end
      GRANT0:  if (cs0_sync || !enable || tmo_hit) state_d = RELEASE;
      GRANT1:  if (cs1_sync || !enable || tmo_hit) state_d = RELEASE;
      RELEASE: if (rel_cnt_q == REL_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rel_cnt_d    = '0;
    last_owner_d = last_owner_q;
    contention_d = contention_q;
    if (state_q == RELEASE) begin
      rel_cnt_d = (rel_cnt_q == REL_LAST) ? rel_cnt_q : rel_cnt_q + 1'b1;
    end
    if (state_q == GRANT0) last_owner_d = REQ_DSP;
    if (state_q == GRANT1) last_owner_d = REQ_CPU;
    if (contention_clr) contention_d = 1'b0;
    if ((state_q == GRANT0 && fall1) || (state_q == GRANT1 && fall0)) begin
      contention_d = 1'b1;
    end
  end

  always_comb begin
    flash_cs_INV = 1'b1;
    flash_clk    = 1'b0;
    flash_mosi   = 1'b0;
    req0_miso    = 1'b1;
    req1_miso    = 1'b1;
    req0_gnt     = 1'b0;
    req1_gnt     = 1'b0;
    case (state_q)
      GRANT0: begin
        flash_cs_INV = req0_cs_INV;
        flash_clk    = req0_clk;
        flash_mosi   = req0_mosi;
        req0_miso    = flash_miso;
        req0_gnt     = 1'b1;
      end
      GRANT1: begin
        flash_cs_INV = req1_cs_INV;
        flash_clk    = req1_clk;
        flash_mosi   = req1_mosi;
        req1_miso    = flash_miso;
        req1_gnt     = 1'b1;
      end
      default: ;
    endcase
  end

  assign contention = contention_q;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Directed self-checking bench for spi_flash_arbiter; the watchdog section follows
// whether SPI_FLASH_ARB_TIMEOUT_EN is defined for the build.
module tb_spi_flash_arbiter;

  logic sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  logic reset, enable, contention_clr;
  logic req0_cs_INV, req0_clk, req0_mosi, req0_miso, req0_gnt;
  logic req1_cs_INV, req1_clk, req1_mosi, req1_miso, req1_gnt;
  logic flash_cs_INV, flash_clk, flash_mosi, flash_miso;
  logic contention, timeout_fault;

  int errors = 0;
  int checks = 0;

  spi_flash_arbiter #(
    .RELEASE_CYCLES (4),
    .TIMEOUT_CYCLES (16),
    .SYNC_STAGES    (2)
  ) dut (
    .sysclk         (sysclk),
    .reset          (reset),
    .enable         (enable),
    .req0_cs_INV    (req0_cs_INV),
    .req0_clk       (req0_clk),
    .req0_mosi      (req0_mosi),
    .req0_miso      (req0_miso),
    .req0_gnt       (req0_gnt),
    .req1_cs_INV    (req1_cs_INV),
    .req1_clk       (req1_clk),
    .req1_mosi      (req1_mosi),
    .req1_miso      (req1_miso),
    .req1_gnt       (req1_gnt),
    .flash_cs_INV   (flash_cs_INV),
    .flash_clk      (flash_clk),
    .flash_mosi     (flash_mosi),
    .flash_miso     (flash_miso),
    .contention_clr (contention_clr),
    .contention     (contention),
    .timeout_fault  (timeout_fault)
  );

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0b exp=%0b", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".gnt0"},  req0_gnt, 1'b0);
    check({tag, ".gnt1"},  req1_gnt, 1'b0);
    check({tag, ".fcs"},   flash_cs_INV, 1'b1);
    check({tag, ".fclk"},  flash_clk, 1'b0);
    check({tag, ".fmosi"}, flash_mosi, 1'b0);
    check({tag, ".miso0"}, req0_miso, 1'b1);
    check({tag, ".miso1"}, req1_miso, 1'b1);
    check({tag, ".cont"},  contention, 1'b0);
    check({tag, ".tmo"},   timeout_fault, 1'b0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; contention_clr = 1'b0;
    req0_cs_INV = 1'b1; req0_clk = 1'b0; req0_mosi = 1'b0;
    req1_cs_INV = 1'b1; req1_clk = 1'b0; req1_mosi = 1'b0;
    flash_miso = 1'b0;

    tick(2);
    check_reset_state("rst");
    reset = 1'b0;
    tick(1);
    $display("txn: reset values");

    // Single request from the DSP: latency and pin mirroring
    req0_cs_INV = 1'b0;
    tick(2);
    check("t1.gnt0_early", req0_gnt, 1'b0);
    tick(1);
    check("t1.gnt0", req0_gnt, 1'b1);
    check("t1.gnt1", req1_gnt, 1'b0);
    check("t1.fcs", flash_cs_INV, 1'b0);
    req0_clk = 1'b1; req0_mosi = 1'b1; flash_miso = 1'b0;
    #1;
    check("t1.fclk", flash_clk, 1'b1);
    check("t1.fmosi", flash_mosi, 1'b1);
    check("t1.miso0_lo", req0_miso, 1'b0);
    check("t1.miso1", req1_miso, 1'b1);
    flash_miso = 1'b1;
    #1;
    check("t1.miso0_hi", req0_miso, 1'b1);
    req0_clk = 1'b0; req0_mosi = 1'b0; flash_miso = 1'b0;
    req0_cs_INV = 1'b1;
    #1;
    check("t1.fcs_rel", flash_cs_INV, 1'b1);
    tick(2);
    check("t1.gnt0_hold", req0_gnt, 1'b1);
    tick(1);
    check("t1.gnt0_drop", req0_gnt, 1'b0);
    tick(6);
    $display("txn: single DSP request");

    // Simultaneous requests: DSP wins first tie, CPU wins the next
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    req0_cs_INV = 1'b0; req1_cs_INV = 1'b0;
    tick(2);
    check("t2.gnt0_early", req0_gnt, 1'b0);
    tick(1);
    check("t2.tie1_gnt0", req0_gnt, 1'b1);
    check("t2.tie1_gnt1", req1_gnt, 1'b0);
    tick(3);
    check("t2.tie1_cont", contention, 1'b0);
    req0_cs_INV = 1'b1; req1_cs_INV = 1'b1;
    tick(3);
    check("t2.rel_gnt0", req0_gnt, 1'b0);
    tick(6);
    req0_cs_INV = 1'b0; req1_cs_INV = 1'b0;
    tick(3);
    check("t2.tie2_gnt1", req1_gnt, 1'b1);
    check("t2.tie2_gnt0", req0_gnt, 1'b0);
    check("t2.tie2_cont", contention, 1'b0);
    req0_cs_INV = 1'b1; req1_cs_INV = 1'b1;
    tick(10);
    $display("txn: tie-break alternation");

    // Contention while the CPU owns the flash, then guard interval and handover
    req1_cs_INV = 1'b0;
    tick(3);
    check("t3.gnt1", req1_gnt, 1'b1);
    req0_cs_INV = 1'b0;
    tick(2);
    check("t3.cont_early", contention, 1'b0);
    tick(1);
    check("t3.cont_set", contention, 1'b1);
    check("t3.miso0", req0_miso, 1'b1);
    flash_miso = 1'b0;
    #1;
    check("t3.miso1", req1_miso, 1'b0);
    req1_cs_INV = 1'b1;
    #1;
    check("t3.fcs_rel", flash_cs_INV, 1'b1);
    tick(3);
    check("t3.gnt1_drop", req1_gnt, 1'b0);
    tick(4);
    check("t3.guard_gnt0", req0_gnt, 1'b0);
    tick(1);
    check("t3.gnt0", req0_gnt, 1'b1);
    check("t3.cont_sticky", contention, 1'b1);
    contention_clr = 1'b1;
    tick(1);
    contention_clr = 1'b0;
    check("t3.cont_clr", contention, 1'b0);
    req0_cs_INV = 1'b1;
    tick(10);
    $display("txn: contention and handover");

    // Enable dropped mid-transfer
    req0_cs_INV = 1'b0;
    tick(3);
    check("t4.gnt0", req0_gnt, 1'b1);
    req0_clk = 1'b1;
    #1;
    check("t4.fclk", flash_clk, 1'b1);
    enable = 1'b0;
    tick(1);
    check("t4.fcs", flash_cs_INV, 1'b1);
    check("t4.fclk_off", flash_clk, 1'b0);
    check("t4.gnt0_off", req0_gnt, 1'b0);
    tick(10);
    check("t4.dis_gnt0", req0_gnt, 1'b0);
    check("t4.dis_gnt1", req1_gnt, 1'b0);
    enable = 1'b1;
    tick(1);
    check("t4.reen_gnt0", req0_gnt, 1'b1);
    req0_clk = 1'b0; req0_cs_INV = 1'b1;
    tick(10);
    $display("txn: enable revoke");

`ifdef SPI_FLASH_ARB_TIMEOUT_EN
    // Watchdog revokes a 40-cycle hold after 16 granted cycles
    req0_cs_INV = 1'b0;
    tick(3);
    check("t5.gnt0", req0_gnt, 1'b1);
    tick(15);
    check("t5.gnt0_c15", req0_gnt, 1'b1);
    check("t5.tmo_early", timeout_fault, 1'b0);
    tick(1);
    check("t5.gnt0_revoked", req0_gnt, 1'b0);
    check("t5.tmo_set", timeout_fault, 1'b1);
    check("t5.fcs", flash_cs_INV, 1'b1);
    tick(21);
    check("t5.locked", req0_gnt, 1'b0);
    req0_cs_INV = 1'b1;
    tick(3);
    req0_cs_INV = 1'b0;
    tick(2);
    check("t5.regrant_early", req0_gnt, 1'b0);
    tick(1);
    check("t5.regrant", req0_gnt, 1'b1);
    check("t5.tmo_sticky", timeout_fault, 1'b1);
    req0_cs_INV = 1'b1;
    tick(10);
    $display("txn: watchdog timeout");
`else
    req0_cs_INV = 1'b0;
    tick(3);
    check("t5.gnt0", req0_gnt, 1'b1);
    tick(37);
    check("t5.gnt0_long", req0_gnt, 1'b1);
    check("t5.tmo_tied", timeout_fault, 1'b0);
    req0_cs_INV = 1'b1;
    tick(10);
    $display("txn: long hold without watchdog");
`endif

    // Reset pulsed while the CPU owns the flash
    req1_cs_INV = 1'b0;
    tick(3);
    check("t6.gnt1", req1_gnt, 1'b1);
    req0_cs_INV = 1'b0;
    tick(3);
    check("t6.cont", contention, 1'b1);
    req1_clk = 1'b1; req1_mosi = 1'b1;
    #1;
    check("t6.fmosi", flash_mosi, 1'b1);
    reset = 1'b1;
    tick(1);
    check_reset_state("t6");
    reset = 1'b0;
    req0_cs_INV = 1'b1; req1_cs_INV = 1'b1; req1_clk = 1'b0; req1_mosi = 1'b0;
    tick(2);
    $display("txn: reset during grant");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
